operand_sequencer: RTL
======================

# operand_sequencer

- Front-end controller for the two-operand seven-segment arithmetic display.
- Turns a single "Next" button and an 8-bit switch bank into the datapath control sequence: load operand A, load operand B, then step through the four display operations.
- Drives the datapath's `Ain`/`Bin`, `Sel`, `E` and `Operation` inputs.
- Guarantees the datapath's level-sensitive operand latches never see data and select change while enabled.

## Interface
Parameters:
- `CYCLE_TICKS`, default 50_000_000: Clock cycles per automatic operation step. Used only with `AUTO_CYCLE_EN`; must be ≥ 2.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Next`  in  1  raw push-button level, asynchronous to `Clock`, already debounced upstream.
- `Switches`  in  8  operand value from the switch bank.
- `DataOut`  out  8  registered operand value, wired to both datapath `Ain` and `Bin`.
- `Sel`  out  1  registered operand select: 0 = A, 1 = B.
- `E`  out  1  registered operand-latch enable.
- `Operation`  out  2  registered display operation: 00 A, 01 B, 10 A+B, 11 A^B.
- `State`  out  2  current state code, for status LEDs.

## Operation
Input conditioning:
- `Next` passes through a two-flop synchronizer, then a rising-edge detector, producing a one-cycle internal `Pulse`.
- An `Armed` flag clears on reset and sets the first cycle the synchronized `Next` is 0. `Pulse` is suppressed while `Armed` = 0, so a button held through reset produces no step.

States (`State` code):
- IDLE (00): `E` = 0. On `Pulse`, go to LOAD_A.
- LOAD_A (01): `Sel` = 0, `E` = 1, `DataOut` <= `Switches` every cycle.
  - On `Pulse`, enter a one-cycle gap: `E` = 0, with `Sel` and `DataOut` held.
  - Then go to LOAD_B.
- LOAD_B (10): `Sel` = 1, `E` = 1, `DataOut` <= `Switches` every cycle.
  - On `Pulse`, enter a one-cycle gap: `E` = 0, with `Sel` and `DataOut` held.
  - Then go to SHOW with `Operation` = 00.
- SHOW (11): `E` = 0; `DataOut` and `Sel` hold their last values.
  - Manual stepping: see Configuration.

Gap rules:
- `E` never rises or falls in the same cycle that `Sel` or `DataOut` changes.
- A `Pulse` during a gap cycle is ignored.

Reset (asynchronous) clears every register:
- `State` = 00, `E` = 0, `Sel` = 0, `DataOut` = 0x00, `Operation` = 00.
- Synchronizer, edge detector, `Armed`, tick counter and gap flag are all 0.
- Reset mid-sequence abandons the sequence; the operands already latched in the datapath are not the controller's concern.

## Timing
- `Next` rising before Clock edge k: `Pulse` is high during cycle k+1→k+2 (suppressed if `Armed` = 0); the state/output update appears after edge k+2.
- LOAD→LOAD and LOAD→SHOW take two edges after `Pulse`: the gap edge, then the new-state edge.
- Every output is a flop output, so the datapath sees no combinational glitches.
- `Switches` to `DataOut`: 1 cycle while in a LOAD state.

## Configuration
- Macro `OPSEQ_AUTO_CYCLE_EN`.
- Defined:
  - In SHOW, a tick counter sized `$clog2(CYCLE_TICKS)` counts from 0.
  - At `CYCLE_TICKS-1`, `Operation` increments (11 wraps to 00, staying in SHOW) and the counter returns to 0.
  - `Pulse` in SHOW goes to LOAD_A with `Operation` = 00 and the counter at 0.
  - `Pulse` and a tick in the same cycle: `Pulse` wins and no increment occurs.
  - The counter is held at 0 outside SHOW.
- Undefined:
  - No counter; `CYCLE_TICKS` is ignored.
  - In SHOW, `Pulse` increments `Operation` (00→01→10→11).
  - `Pulse` at 11 sets `Operation` = 00 and goes to LOAD_A.

## Test plan
- Reset released with `Next` = 0, no stimulus → `State` = 00, `E` = 0, `DataOut` = 0x00, `Operation` = 00 held indefinitely.
- Full load sequence: press, `Switches` = 0x2A, press, `Switches` = 0xC3, press.
  - Datapath latches A = 0x2A and B = 0xC3.
  - Exactly one `E` = 0 gap precedes each `Sel` change.
  - `State` = 11.
- Manual build: four presses in SHOW → `Operation` 01, 10, 11, then 00 with `State` = 01. With A = 0x2A and B = 0xC3, datapath shows 042, 195, 237, 233 in that order.
- `Next` held high across reset assertion and release → no state change until `Next` goes low, then high again.
- Auto build with `CYCLE_TICKS` = 4: `Operation` steps every 4 cycles 00→01→10→11→00. A press coinciding with a tick → `State` = 01, `Operation` = 00.
- Reset asserted asynchronously mid-LOAD_B with `E` = 1 → `E` = 0 and `State` = 00 before the next Clock edge.

Source files
------------

// File: rtl/operand_sequencer.sv
// Button/switch front end for the two-operand seven-segment display: sequences operand loads and display ops.
// Optional OPSEQ_AUTO_CYCLE_EN: SHOW steps Operation automatically every CYCLE_TICKS clocks.
module operand_sequencer #(
    parameter int CYCLE_TICKS = 50_000_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Next,
    input  logic [7:0] Switches,
    output logic [7:0] DataOut,
    output logic       Sel,
    output logic       E,
    output logic [1:0] Operation,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD_A = 2'b01,
        LOAD_B = 2'b10,
        SHOW   = 2'b11
    } state_t;

    if (CYCLE_TICKS < 2) begin : g_bad_ticks
        $error("CYCLE_TICKS must be at least 2");
    end

    state_t     state, state_n;
    logic       gap, gap_n;
    logic [7:0] data_n;
    logic       sel_n, e_n;
    logic [1:0] op_n;

    logic       sync1, sync2, sync_prev;
    logic [1:0] live;
    logic       armed;
    logic       pulse;

    // live marks when sync2 holds a real sample of Next rather than its reset
    // value, so a button held through reset never arms the edge detector.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            live      <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync1     <= Next;
            sync2     <= sync1;
            sync_prev <= sync2;
            live      <= {live[0], 1'b1};
            armed     <= armed | (live[1] & ~sync2);
        end
    end

    assign pulse = sync2 & ~sync_prev & armed;

`ifdef OPSEQ_AUTO_CYCLE_EN
    localparam int CW = $clog2(CYCLE_TICKS);
    localparam logic [CW-1:0] LAST_TICK = CW'(CYCLE_TICKS - 1);
    logic [CW-1:0] tick_cnt, tick_cnt_n;
`endif

    always_comb begin
        state_n = state;
        gap_n   = gap;
        data_n  = DataOut;
        sel_n   = Sel;
        e_n     = E;
        op_n    = Operation;
`ifdef OPSEQ_AUTO_CYCLE_EN
        tick_cnt_n = '0;
`endif
        case (state)
            IDLE: begin
                e_n = 1'b0;
                if (pulse) begin
                    state_n = LOAD_A;
                    sel_n   = 1'b0;
                end
            end
            LOAD_A, LOAD_B: begin
                // E only moves on edges where Sel and DataOut are held; the first
                // cycle of a load raises E before data starts tracking Switches.
                if (gap) begin
                    gap_n = 1'b0;
                    e_n   = 1'b0;
                    if (state == LOAD_A) begin
                        state_n = LOAD_B;
                        sel_n   = 1'b1;
                    end else begin
                        state_n = SHOW;
                        op_n    = 2'b00;
                    end
                end else if (pulse) begin
                    gap_n = 1'b1;
                    e_n   = 1'b0;
                end else if (!E) begin
                    e_n = 1'b1;
                end else begin
                    data_n = Switches;
                end
            end
            SHOW: begin
                e_n = 1'b0;
`ifdef OPSEQ_AUTO_CYCLE_EN
                if (pulse) begin
                    state_n = LOAD_A;
                    sel_n   = 1'b0;
                    op_n    = 2'b00;
                end else if (tick_cnt == LAST_TICK) begin
                    op_n = Operation + 2'd1;
                end else begin
                    tick_cnt_n = tick_cnt + 1'b1;
                end
`else
                if (pulse) begin
                    if (Operation == 2'b11) begin
                        state_n = LOAD_A;
                        sel_n   = 1'b0;
                        op_n    = 2'b00;
                    end else begin
                        op_n = Operation + 2'd1;
                    end
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            gap       <= 1'b0;
            DataOut   <= 8'h00;
            Sel       <= 1'b0;
            E         <= 1'b0;
            Operation <= 2'b00;
`ifdef OPSEQ_AUTO_CYCLE_EN
            tick_cnt  <= '0;
`endif
        end else begin
            state     <= state_n;
            gap       <= gap_n;
            DataOut   <= data_n;
            Sel       <= sel_n;
            E         <= e_n;
            Operation <= op_n;
`ifdef OPSEQ_AUTO_CYCLE_EN
            tick_cnt  <= tick_cnt_n;
`endif
        end
    end

    assign State = state;

endmodule
